fairy_wb_stage: RTL and testbench

FAIRY_WB_STAGE -- requirements
Module: fairy_wb_stage

---
 rtl/fairy_wb_stage.sv | 175 +++++++++++++++++
 tb/tb_fairy_wb_stage.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fairy_wb_stage.sv
// Write-back stage of the fairy pipeline: holds the retiring instruction in a
// stage register, commits GPR and HI/LO writes, raises precise exceptions and
// ERET, and counts retired instructions. One flush cycle follows every
// exception or ERET so that the upstream refill never retires wrong-path work.
module fairy_wb_stage #(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC00380
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] inst_i,
    input  logic [31:0] pc_i,
    input  logic [63:0] data_i,
    input  logic [4:0]  reg_waddr_i,
    input  logic        reg_we_i,
    input  logic [1:0]  hilo_we_i,
    input  logic        delayslot_i,
    input  logic        overflow_i,
    input  logic        unaligned_addr_i,
    input  logic        illegal_inst_i,
    input  logic [31:0] epc_i,
    output logic        rf_we_o,
    output logic [4:0]  rf_waddr_o,
    output logic [31:0] rf_wdata_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        exception_o,
    output logic        eret_o,
    output logic [4:0]  exc_code_o,
    output logic [31:0] exc_epc_o,
    output logic        exc_bd_o,
    output logic [31:0] redirect_pc_o,
    output logic [31:0] instret_o
);

    localparam logic [31:0] ERET_INST = 32'h42000018;
    localparam logic [4:0]  CODE_ADEL = 5'd4;
    localparam logic [4:0]  CODE_ADES = 5'd5;
    localparam logic [4:0]  CODE_RI   = 5'd10;
    localparam logic [4:0]  CODE_OV   = 5'd12;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t      state_reg;

    // Stage register fields
    logic [31:0] s_inst_reg;
    logic [31:0] s_pc_reg;
    logic [63:0] s_data_reg;
    logic [4:0]  s_waddr_reg;
    logic        s_we_reg;
    logic [1:0]  s_hilo_we_reg;
    logic        s_ds_reg;
    logic        s_ov_reg;
    logic        s_unal_reg;
    logic        s_ill_reg;

    logic [31:0] hi_reg;
    logic [31:0] lo_reg;
    logic [31:0] instret_reg;

    logic        in_run;
    logic        exc;
    logic        commit_ok;
    logic        squash;

    assign in_run    = (state_reg == RUN);
    assign exc       = s_ill_reg | s_ov_reg | s_unal_reg;
    // Anything architecturally visible only happens for a clean instruction in RUN
    assign commit_ok = in_run & ~exc;

    assign exception_o = exc & in_run;
    assign eret_o      = (s_inst_reg == ERET_INST) & commit_ok;
    // Whatever arrives while a redirect is pending or in progress is wrong-path
    assign squash      = (state_reg == FLUSH) | exception_o | eret_o;

    assign rf_we_o    = s_we_reg & (s_waddr_reg != 5'd0) & commit_ok;
    assign rf_waddr_o = s_waddr_reg;
    assign rf_wdata_o = s_data_reg[31:0];

    assign hi_o      = hi_reg;
    assign lo_o      = lo_reg;
    assign instret_o = instret_reg;

    // Exception cause and victim PC; all zero unless an exception is being taken
    always_comb begin
        exc_code_o = 5'd0;
        exc_epc_o  = 32'd0;
        exc_bd_o   = 1'b0;
        if (exception_o) begin
            if (s_ill_reg)
                exc_code_o = CODE_RI;
            else if (s_ov_reg)
                exc_code_o = CODE_OV;
            else
                exc_code_o = s_inst_reg[29] ? CODE_ADES : CODE_ADEL;
            // A delay-slot victim restarts at its branch
            exc_epc_o = s_ds_reg ? (s_pc_reg - 32'd4) : s_pc_reg;
            exc_bd_o  = s_ds_reg;
        end
    end

    // Fetch redirect target for exception entry or ERET return
    always_comb begin
        redirect_pc_o = 32'd0;
        if (exception_o)
            redirect_pc_o = EXC_VECTOR;
        else if (eret_o)
            redirect_pc_o = epc_i;
    end

    // Stage register: capture the incoming instruction or insert a bubble
    always_ff @(posedge clk) begin
        if (reset || squash) begin
            s_inst_reg    <= 32'd0;
            s_pc_reg      <= 32'd0;
            s_data_reg    <= 64'd0;
            s_waddr_reg   <= 5'd0;
            s_we_reg      <= 1'b0;
            s_hilo_we_reg <= 2'b00;
            s_ds_reg      <= 1'b0;
            s_ov_reg      <= 1'b0;
            s_unal_reg    <= 1'b0;
            s_ill_reg     <= 1'b0;
        end else begin
            s_inst_reg    <= inst_i;
            s_pc_reg      <= pc_i;
            s_data_reg    <= data_i;
            s_waddr_reg   <= reg_waddr_i;
            s_we_reg      <= reg_we_i;
            s_hilo_we_reg <= hilo_we_i;
            s_ds_reg      <= delayslot_i;
            s_ov_reg      <= overflow_i;
            s_unal_reg    <= unaligned_addr_i;
            s_ill_reg     <= illegal_inst_i;
        end
    end

    // RUN/FLUSH sequencing: a single flush cycle after each redirect
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= RUN;
        end else begin
            case (state_reg)
                RUN:     if (exception_o || eret_o) state_reg <= FLUSH;
                FLUSH:   state_reg <= RUN;
                default: state_reg <= RUN;
            endcase
        end
    end

    // HI/LO commit; both halves may be written on the same edge
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_reg <= 32'd0;
            lo_reg <= 32'd0;
        end else begin
            if (commit_ok && s_hilo_we_reg[1])
                hi_reg <= s_data_reg[63:32];
            if (commit_ok && s_hilo_we_reg[0])
                lo_reg <= s_data_reg[31:0];
        end
    end

    // Retired-instruction counter; bubbles do not count, ERET does
    always_ff @(posedge clk) begin
        if (reset)
            instret_reg <= 32'd0;
        else if (commit_ok && (s_inst_reg != 32'd0))
            instret_reg <= instret_reg + 32'd1;
    end

endmodule

// File: tb/tb_fairy_wb_stage.sv
// Bench for fairy_wb_stage: directed scenarios followed by random traffic,
// each compared against a transaction-level model of retirement.
module tb_fairy_wb_stage;

    localparam logic [31:0] EXC_VEC   = 32'hBFC00380;
    localparam logic [31:0] ERET_INST = 32'h42000018;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [63:0] data;
        logic [4:0]  waddr;
        logic        we;
        logic [1:0]  hilo;
        logic        ds;
        logic        ov;
        logic        un;
        logic        ill;
        logic [31:0] epc;
    } txn_t;

    logic        clk;
    logic        reset;
    logic [31:0] inst_i;
    logic [31:0] pc_i;
    logic [63:0] data_i;
    logic [4:0]  reg_waddr_i;
    logic        reg_we_i;
    logic [1:0]  hilo_we_i;
    logic        delayslot_i;
    logic        overflow_i;
    logic        unaligned_addr_i;
    logic        illegal_inst_i;
    logic [31:0] epc_i;
    logic        rf_we_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        exception_o;
    logic        eret_o;
    logic [4:0]  exc_code_o;
    logic [31:0] exc_epc_o;
    logic        exc_bd_o;
    logic [31:0] redirect_pc_o;
    logic [31:0] instret_o;

    fairy_wb_stage #(.EXC_VECTOR(EXC_VEC)) dut (
        .clk              (clk),
        .reset            (reset),
        .inst_i           (inst_i),
        .pc_i             (pc_i),
        .data_i           (data_i),
        .reg_waddr_i      (reg_waddr_i),
        .reg_we_i         (reg_we_i),
        .hilo_we_i        (hilo_we_i),
        .delayslot_i      (delayslot_i),
        .overflow_i       (overflow_i),
        .unaligned_addr_i (unaligned_addr_i),
        .illegal_inst_i   (illegal_inst_i),
        .epc_i            (epc_i),
        .rf_we_o          (rf_we_o),
        .rf_waddr_o       (rf_waddr_o),
        .rf_wdata_o       (rf_wdata_o),
        .hi_o             (hi_o),
        .lo_o             (lo_o),
        .exception_o      (exception_o),
        .eret_o           (eret_o),
        .exc_code_o       (exc_code_o),
        .exc_epc_o        (exc_epc_o),
        .exc_bd_o         (exc_bd_o),
        .redirect_pc_o    (redirect_pc_o),
        .instret_o        (instret_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total_cnt = 0;
    int bad_cnt   = 0;
    int txn_no    = 0;

    // Reference model: architectural HI/LO/instret plus how many upcoming
    // inputs are discarded after a taken exception or ERET
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic [31:0] m_instret;
    int          squash_left;
    txn_t        pend;
    logic        pend_acc;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s txn=%0d got=%h want=%h", tag, txn_no, got, exp);
        end
    endtask

    task automatic drive(input txn_t t);
        inst_i           = t.inst;
        pc_i             = t.pc;
        data_i           = t.data;
        reg_waddr_i      = t.waddr;
        reg_we_i         = t.we;
        hilo_we_i        = t.hilo;
        delayslot_i      = t.ds;
        overflow_i       = t.ov;
        unaligned_addr_i = t.un;
        illegal_inst_i   = t.ill;
        epc_i            = t.epc;
    endtask

    function automatic txn_t rand_txn();
        txn_t t;
        t.pc    = {$urandom_range(0, 32'h3FFFFFFF), 2'b00};
        t.data  = {$urandom, $urandom};
        t.waddr = 5'($urandom_range(0, 31));
        t.we    = 1'($urandom_range(0, 1));
        t.hilo  = 2'($urandom_range(0, 3));
        t.ds    = 1'($urandom_range(0, 1));
        t.ov    = ($urandom_range(0, 9) == 0);
        t.un    = ($urandom_range(0, 9) == 0);
        t.ill   = ($urandom_range(0, 11) == 0);
        t.epc   = $urandom;
        case ($urandom_range(0, 9))
            0:       t.inst = 32'd0;
            1:       t.inst = ERET_INST;
            2:       t.inst = 32'hAC000000;
            3:       t.inst = 32'h8C000000;
            default: t.inst = $urandom;
        endcase
        return t;
    endfunction

    function automatic logic has_exc(input txn_t t);
        return t.ill | t.ov | t.un;
    endfunction

    function automatic logic is_eret(input txn_t t);
        return (t.inst == ERET_INST) && !has_exc(t);
    endfunction

    // Compare what the DUT shows for the pending transaction
    task automatic check_pending();
        txn_t        e;
        logic        x;
        logic        er;
        logic [4:0]  code;
        logic [31:0] epc;
        logic [31:0] redir;
        e  = pend_acc ? pend : '0;
        x  = has_exc(e);
        er = is_eret(e);
        code  = 5'd0;
        epc   = 32'd0;
        redir = 32'd0;
        if (x) begin
            if (e.ill)     code = 5'd10;
            else if (e.ov) code = 5'd12;
            else           code = e.inst[29] ? 5'd5 : 5'd4;
            epc   = e.ds ? e.pc - 32'd4 : e.pc;
            redir = EXC_VEC;
        end else if (er) begin
            redir = epc_i;
        end
        $display("txn %0d inst=%h accepted=%0d exc=%0d eret=%0d", txn_no, pend.inst, pend_acc, x, er);
        check_eq("rf_we",    64'(rf_we_o),       64'(e.we && e.waddr != 0 && !x));
        check_eq("rf_waddr", 64'(rf_waddr_o),    64'(e.waddr));
        check_eq("rf_wdata", 64'(rf_wdata_o),    64'(e.data[31:0]));
        check_eq("hi",       64'(hi_o),          64'(m_hi));
        check_eq("lo",       64'(lo_o),          64'(m_lo));
        check_eq("exception",64'(exception_o),   64'(x));
        check_eq("eret",     64'(eret_o),        64'(er));
        check_eq("exc_code", 64'(exc_code_o),    64'(code));
        check_eq("exc_epc",  64'(exc_epc_o),     64'(epc));
        check_eq("exc_bd",   64'(exc_bd_o),      64'(x & e.ds));
        check_eq("redirect", 64'(redirect_pc_o), 64'(redir));
        check_eq("instret",  64'(instret_o),     64'(m_instret));
        // Architectural effect of the pending transaction
        if (!x) begin
            if (e.hilo[1]) m_hi = e.data[63:32];
            if (e.hilo[0]) m_lo = e.data[31:0];
            if (e.inst != 32'd0) m_instret = m_instret + 32'd1;
        end
        txn_no++;
    endtask

    // Present a new input; it is seen at the next edge and checked one cycle later
    task automatic step(input txn_t t);
        @(posedge clk);
        #1;
        check_pending();
        drive(t);
        pend     = t;
        pend_acc = (squash_left == 0);
        if (squash_left > 0) squash_left--;
        if (pend_acc && (has_exc(t) || is_eret(t))) squash_left = 2;
    endtask

    task automatic model_clear();
        m_hi        = 32'd0;
        m_lo        = 32'd0;
        m_instret   = 32'd0;
        squash_left = 0;
        pend        = '0;
        pend_acc    = 1'b1;
    endtask

    // Synchronous reset for one edge with junk on the inputs, then expect all zeros
    task automatic do_reset();
        @(posedge clk);
        #1;
        check_pending();
        reset = 1'b1;
        drive(rand_txn());
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_clear();
        drive('0);
        check_pending();
    endtask

    txn_t t;

    initial begin
        reset = 1'b1;
        drive('0);
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check_pending();

        // ADDU r5 = 0x1234
        t = '0; t.inst = 32'h00A62821; t.pc = 32'hBFC00000; t.data = 64'h1234; t.waddr = 5'd5; t.we = 1'b1;
        step(t);
        // write to r0 is dropped but still retires
        t = '0; t.inst = 32'h00A60021; t.pc = 32'hBFC00004; t.data = 64'h55; t.waddr = 5'd0; t.we = 1'b1;
        step(t);
        // MULT writes HI and LO together
        t = '0; t.inst = 32'h00A60018; t.pc = 32'hBFC00008; t.data = 64'hAAAA_0000_0000_BBBB; t.hilo = 2'b11;
        step(t);
        step('0);
        // overflow in a delay slot
        t = '0; t.inst = 32'h00A62820; t.pc = 32'hBFC00104; t.ds = 1'b1; t.ov = 1'b1; t.we = 1'b1; t.waddr = 5'd7; t.data = 64'hDEAD;
        step(t);
        t = '0; t.inst = 32'h00A63021; t.pc = 32'hBFC00108; t.we = 1'b1; t.waddr = 5'd6; t.data = 64'h77; t.hilo = 2'b01;
        step(t);
        step(t);
        step('0);
        // illegal takes priority over overflow
        t = '0; t.inst = 32'hFC000000; t.pc = 32'hBFC00200; t.ill = 1'b1; t.ov = 1'b1;
        step(t);
        step('0);
        step('0);
        // unaligned store
        t = '0; t.inst = 32'hAC000000; t.pc = 32'hBFC00300; t.un = 1'b1;
        step(t);
        step('0);
        step('0);
        // ERET, then an exception on the very next input is ignored
        t = '0; t.inst = ERET_INST; t.pc = 32'hBFC00400; t.epc = 32'h8000_0040;
        step(t);
        t = '0; t.inst = 32'h00000020; t.pc = 32'h80000040; t.ov = 1'b1;
        step(t);
        // reset lands on the flush cycle
        do_reset();
        t = '0; t.inst = 32'h00A62821; t.data = 64'h99; t.waddr = 5'd3; t.we = 1'b1;
        step(t);

        // random traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0)
                do_reset();
            else
                step(rand_txn());
        end
        step('0);
        step('0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
